// File: rtl/pcs_loopback_buf.sv
// pcs_loopback_buf
// ----------------
// Elastic buffer on the RX->TX loopback path, in logic_clk. pcs_rx cannot be
// stalled, but pcs_tx drops ready during marker and gearbox slots. This block
// absorbs those stalls in a small FIFO. When the FIFO is nearly full, it
// deletes inter-frame idle blocks. When it runs dry, it synthesises idle (or
// error) blocks, so pcs_tx always sees a legal block stream.
//
// Optional build macro: LOOPBACK_STATS_EN. When it is defined, the
// deletion/insertion/underflow counters are built. When it is undefined, the
// counter outputs are tied to zero. Datapath behaviour is the same in both
// builds.
//
// Ports
//   clk, reset                 logic_clk, synchronous active-high reset
//   valid_i                    pcs_rx block valid this cycle
//   ctrl_v_i/idle_v_i/
//   term_v_i/err_v_i           pcs_rx block flags
//   start_v_i[LANE0_CNT_N]     start flag per lane-0 position
//   data_i[DATA_W], keep_i     block data and byte keep
//   ready_i                    pcs_tx ready; output registers hold while low
//   ctrl_v_o..keep_o           block presented to pcs_tx
//   fill_o                     current FIFO occupancy, 0..DEPTH
//   overflow_o                 sticky, a non-idle block was lost
//   del_cnt_o/ins_cnt_o/
//   unf_cnt_o                  saturating 16-bit statistics

module pcs_loopback_buf #(
    parameter int IS_10G   = 1,
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 16,
    parameter int START_WM = 4,
    parameter int HI_WM    = 12,
    localparam int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1,
    localparam int KEEP_W      = DATA_W / 8,
    localparam int FILL_W      = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic                   ctrl_v_i,
    input  logic                   idle_v_i,
    input  logic                   term_v_i,
    input  logic                   err_v_i,
    input  logic [LANE0_CNT_N-1:0] start_v_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic [KEEP_W-1:0]      keep_i,
    input  logic                   ready_i,
    output logic                   ctrl_v_o,
    output logic                   idle_v_o,
    output logic                   term_v_o,
    output logic                   err_v_o,
    output logic [LANE0_CNT_N-1:0] start_v_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [KEEP_W-1:0]      keep_o,
    output logic [FILL_W-1:0]      fill_o,
    output logic                   overflow_o,
    output logic [15:0]            del_cnt_o,
    output logic [15:0]            ins_cnt_o,
    output logic [15:0]            unf_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [FILL_W-1:0] DEPTH_F    = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] START_WM_F = FILL_W'(START_WM);
    localparam logic [FILL_W-1:0] HI_WM_F    = FILL_W'(HI_WM);

    typedef struct packed {
        logic                   ctrl;
        logic                   idle;
        logic                   term;
        logic                   err;
        logic [LANE0_CNT_N-1:0] start;
        logic [KEEP_W-1:0]      keep;
        logic [DATA_W-1:0]      data;
    } blk_t;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic blk_t idle_blk();
        blk_t b;
        b      = '0;
        b.ctrl = 1'b1;
        b.idle = 1'b1;
        return b;
    endfunction

    function automatic blk_t err_blk();
        blk_t b;
        b      = '0;
        b.ctrl = 1'b1;
        b.err  = 1'b1;
        return b;
    endfunction

    blk_t             mem [DEPTH];
    blk_t             in_blk;
    blk_t             head;
    blk_t             out_q;
    blk_t             out_next;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill;
    logic              in_frame_w;
    logic              in_frame_r;
    logic              in_frame_r_next;
    logic              overflow;

    state_t            state;
    state_t            state_next;

    logic              pop;
    logic              del_blk;
    logic              drop_blk;
    logic              wr_en;
    logic              ins_inc;
    logic              unf_inc;

    always_comb begin
        in_blk       = '0;
        in_blk.ctrl  = ctrl_v_i;
        in_blk.idle  = idle_v_i;
        in_blk.term  = term_v_i;
        in_blk.err   = err_v_i;
        in_blk.start = start_v_i;
        in_blk.keep  = keep_i;
        in_blk.data  = data_i;
    end

    assign head = mem[rd_ptr];

    // Write-side decisions use the registered fill. A full FIFO still accepts
    // a block when a pop frees a slot in the same cycle.
    assign del_blk  = valid_i && idle_v_i && !in_frame_w && (fill >= HI_WM_F);
    assign drop_blk = valid_i && !del_blk && (fill == DEPTH_F) && !pop;
    assign wr_en    = valid_i && !del_blk && !drop_blk;

    // Read-side FSM. Every state presents a block whenever ready_i is high.
    // The PRIME->RUN decision depends only on fill, not on ready_i.
    always_comb begin
        state_next      = state;
        out_next        = out_q;
        pop             = 1'b0;
        ins_inc         = 1'b0;
        unf_inc         = 1'b0;
        in_frame_r_next = in_frame_r;
        case (state)
            PRIME: begin
                if (ready_i) begin
                    out_next = idle_blk();
                end
                if (fill >= START_WM_F) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ready_i) begin
                    if (fill != '0) begin
                        pop      = 1'b1;
                        out_next = head;
                        if (|head.start) begin
                            in_frame_r_next = 1'b1;
                        end else if (head.term) begin
                            in_frame_r_next = 1'b0;
                        end
                    end else if (!in_frame_r) begin
                        out_next = idle_blk();
                        ins_inc  = 1'b1;
                    end else begin
                        // Running dry mid-frame: poison the frame and re-prime.
                        out_next        = err_blk();
                        in_frame_r_next = 1'b0;
                        unf_inc         = 1'b1;
                        state_next      = PRIME;
                    end
                end
            end
            default: state_next = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PRIME;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            in_frame_w <= 1'b0;
            in_frame_r <= 1'b0;
            overflow   <= 1'b0;
            out_q      <= idle_blk();
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            // Frame tracking follows every valid block, kept or not.
            if (valid_i) begin
                if (|start_v_i) begin
                    in_frame_w <= 1'b1;
                end else if (term_v_i) begin
                    in_frame_w <= 1'b0;
                end
            end
            in_frame_r <= in_frame_r_next;
            if (drop_blk && !idle_v_i) begin
                overflow <= 1'b1;
            end
            out_q <= out_next;
        end
    end

    // Storage holds data only; occupancy is tracked by fill and the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_blk;
        end
    end

    assign ctrl_v_o   = out_q.ctrl;
    assign idle_v_o   = out_q.idle;
    assign term_v_o   = out_q.term;
    assign err_v_o    = out_q.err;
    assign start_v_o  = out_q.start;
    assign data_o     = out_q.data;
    assign keep_o     = out_q.keep;
    assign fill_o     = fill;
    assign overflow_o = overflow;

`ifdef LOOPBACK_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] del_cnt;
    logic [15:0] ins_cnt;
    logic [15:0] unf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            del_cnt <= '0;
            ins_cnt <= '0;
            unf_cnt <= '0;
        end else begin
            if (del_blk) begin
                del_cnt <= sat_inc(del_cnt);
            end
            if (ins_inc) begin
                ins_cnt <= sat_inc(ins_cnt);
            end
            if (unf_inc) begin
                unf_cnt <= sat_inc(unf_cnt);
            end
        end
    end

    assign del_cnt_o = del_cnt;
    assign ins_cnt_o = ins_cnt;
    assign unf_cnt_o = unf_cnt;
`else
    logic unused_stats;
    assign unused_stats = ins_inc ^ unf_inc;

    assign del_cnt_o = '0;
    assign ins_cnt_o = '0;
    assign unf_cnt_o = '0;
`endif

endmodule
